// File: rtl/syn_fifo_reader.sv
// Drains an attached synchronous FIFO into a valid/ready stream.
// Reads are issued only in RUN, only while the FIFO reports data, and only while the
// two-entry output buffer can absorb every word already requested. The FIFO returns
// registered data one cycle after a read, so each read is tracked by an in-flight flag
// until its word is captured.
// Optional build macro SYN_FIFO_READER_CNT_EN adds rd_count, a 16-bit wrapping count
// of stream transfers.
module syn_fifo_reader #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_cs,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
`ifdef SYN_FIFO_READER_CNT_EN
  output logic                  busy,
  output logic [15:0]           rd_count
`else
  output logic                  busy
`endif
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  state_e state_q, state_d;

  logic                  inflight_q;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;

  logic       rd_issue;
  logic       xfer;
  logic [1:0] occ_after_xfer;
  logic [1:0] pending;

  // buf0 is always the head of the output buffer.
  assign m_valid = (occ_q != 2'd0);
  assign m_data  = buf0_q;
  assign xfer    = m_valid & m_ready;
  assign busy    = (state_q != StIdle);

  // Words left in the buffer after this cycle's transfer plus the word in flight.
  // Counting the departing word lets a new read overlap a transfer, which keeps the
  // stream gap-free when m_ready stays high.
  assign occ_after_xfer = occ_q - {1'b0, xfer};
  assign pending        = occ_after_xfer + {1'b0, inflight_q};

  // Read-issue term shared by both FIFO read strobes.
  always_comb begin
    rd_issue = 1'b0;
    if ((state_q == StRun) && !fifo_empty && (pending < 2'd2)) begin
      rd_issue = 1'b1;
    end
  end

  assign fifo_rd_cs = rd_issue;
  assign fifo_rd_en = rd_issue;

  // Output buffer next state: pop the head, then append the captured word behind
  // whatever remains so order is preserved when capture and transfer coincide.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = pending;
    if (xfer) begin
      buf0_d = buf1_q;
    end
    if (inflight_q) begin
      if (occ_after_xfer == 2'd0) begin
        buf0_d = fifo_data;
      end else begin
        buf1_d = fifo_data;
      end
    end
  end

  // Buffer, occupancy and in-flight registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf0_q     <= '0;
      buf1_q     <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      occ_q      <= occ_d;
      inflight_q <= rd_issue;
    end
  end

  // Control FSM next state: DRAIN lets requested words finish before going idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!enable) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (enable) begin
          state_d = StRun;
        end else if (!inflight_q && (occ_q == 2'd0)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef SYN_FIFO_READER_CNT_EN
  logic [15:0] rd_count_q;

  // Transfer counter; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count_q <= 16'd0;
    end else if (xfer) begin
      rd_count_q <= rd_count_q + 16'd1;
    end
  end

  assign rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_syn_fifo_reader.sv
// Bench for syn_fifo_reader: a queue-based FIFO model feeds the DUT, and a scoreboard
// expects the stream to reproduce the FIFO write order exactly.
module tb_syn_fifo_reader;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          m_ready = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_rd_cs;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          busy;
`ifdef SYN_FIFO_READER_CNT_EN
  logic [15:0]   rd_count;
`endif

  always #5 clk = ~clk;

  syn_fifo_reader #(
    .DATA_WIDTH(DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd_cs(fifo_rd_cs),
    .fifo_rd_en(fifo_rd_en),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
`ifdef SYN_FIFO_READER_CNT_EN
    .busy      (busy),
    .rd_count  (rd_count)
`else
    .busy      (busy)
`endif
  );

  // Synchronous FIFO model with registered read data; flushed by the shared reset.
  logic [DW-1:0] fifo_mem [256];
  logic [7:0]    wr_ptr = 8'd0;
  logic [7:0]    rd_ptr;
  logic [7:0]    fifo_cnt;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_cnt   = wr_ptr - rd_ptr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= wr_ptr;
      fifo_data <= '0;
    end else if (fifo_rd_cs && fifo_rd_en && !fifo_empty) begin
      fifo_data <= fifo_mem[rd_ptr];
      rd_ptr    <= rd_ptr + 8'd1;
    end
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [DW-1:0] exp_q[$];
  int rd_cnt, x_cnt, first_rd, first_valid, first_x, last_x;
  int xfer_since_rst = 0;
  logic hold_pend = 1'b0;
  logic [DW-1:0] hold_data = '0;

  typedef struct {
    int nwords;
    int stall;
    int exp_stall_reads;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    rd_cnt = 0;
    x_cnt = 0;
    first_rd = -1;
    first_valid = -1;
    first_x = -1;
    last_x = -1;
  endtask

  task automatic push(input logic [DW-1:0] v);
    fifo_mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 8'd1;
    exp_q.push_back(v);
  endtask

  // Per-cycle observation, sampled at the falling edge.
  task automatic mon();
    if (rst) begin
      hold_pend = 1'b0;
      xfer_since_rst = 0;
    end else begin
      if (fifo_rd_en || fifo_rd_cs) chk("rd_strobe_pair", {30'd0, fifo_rd_cs, fifo_rd_en}, 32'd3);
      if (fifo_rd_en) begin
        chk("rd_while_empty", fifo_empty, 0);
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (hold_pend) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, hold_data);
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_word: got %0h with nothing expected (cycle %0d)", m_data, cyc);
        end else begin
          chk("stream_data", m_data, exp_q.pop_front());
        end
        x_cnt++;
        xfer_since_rst++;
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
      end
      hold_pend = m_valid && !m_ready;
      hold_data = m_data;
    end
  endtask

  // One clock: observe at the falling edge, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    mon();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_xfers(input int n, input int budget);
    int k = 0;
    while (x_cnt < n && k < budget) begin
      tick();
      k++;
    end
    chk("xfer_count", x_cnt, n);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    chk("busy_low", busy, 0);
  endtask

  initial begin
    logic [DW-1:0] w0;
    logic [DW-1:0] v;
    int k;

    vecs[0] = '{3, 0, 0};
    vecs[1] = '{4, 5, 2};
    vecs[2] = '{1, 5, 1};
    vecs[3] = '{2, 3, 2};
    vecs[4] = '{5, 0, 0};
    vecs[5] = '{0, 3, 0};

    // Reset state
    repeat (3) tick();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_rd_cs", fifo_rd_cs, 0);
`ifdef SYN_FIFO_READER_CNT_EN
    chk("rst_rd_count", rd_count, 0);
`endif
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // Table-driven scenarios: preload, optional back-pressure, drain.
    for (int r = 0; r < 6; r++) begin
      clear_stats();
      w0 = '0;
      for (int w = 0; w < vecs[r].nwords; w++) begin
        v = (r == 0) ? DW'(8'h11 * (w + 1)) : DW'($urandom_range(0, 255));
        if (w == 0) w0 = v;
        push(v);
      end
      m_ready = (vecs[r].stall == 0);
      enable = 1'b1;
      if (vecs[r].stall > 0) begin
        repeat (vecs[r].stall) tick();
        chk("stall_reads", rd_cnt, vecs[r].exp_stall_reads);
        if (vecs[r].nwords > 0) begin
          chk("stall_valid", m_valid, 1);
          chk("stall_head", m_data, w0);
        end
        m_ready = 1'b1;
      end
      wait_xfers(vecs[r].nwords, 40);
      chk("total_reads", rd_cnt, vecs[r].nwords);
      if (vecs[r].nwords > 0) begin
        chk("first_latency", first_valid - first_rd, 2);
        chk("no_bubbles", last_x - first_x, vecs[r].nwords - 1);
      end
      enable = 1'b0;
      wait_idle(10);
    end

    // Enable dropped in the very cycle the first read issues.
    clear_stats();
    for (int w = 0; w < 3; w++) push(DW'(8'hA0 + w));
    m_ready = 1'b1;
    enable = 1'b1;
    k = 0;
    while (!fifo_rd_en && k < 5) begin
      tick();
      k++;
    end
    chk("drain_read_seen", fifo_rd_en, 1);
    enable = 1'b0;
    tick();
    chk("drain_t1_busy", busy, 1);
    chk("drain_t1_valid", m_valid, 0);
    chk("drain_t1_rd", fifo_rd_en, 0);
    tick();
    chk("drain_t2_valid", m_valid, 1);
    chk("drain_t2_data", m_data, 8'hA0);
    chk("drain_t2_busy", busy, 1);
    tick();
    chk("drain_t3_valid", m_valid, 0);
    chk("drain_t3_busy", busy, 1);
    tick();
    chk("drain_t4_busy", busy, 0);
    repeat (5) tick();
    chk("drain_reads", rd_cnt, 1);
    chk("drain_xfers", x_cnt, 1);
    enable = 1'b1;
    wait_xfers(3, 20);
    enable = 1'b0;
    wait_idle(10);

    // Reset with two words buffered.
    clear_stats();
    for (int w = 0; w < 4; w++) push(DW'(8'hC0 + w));
    m_ready = 1'b0;
    enable = 1'b1;
    repeat (5) tick();
    chk("prerst_reads", rd_cnt, 2);
    chk("prerst_valid", m_valid, 1);
    rst = 1'b1;
    #1;
    chk("midrst_valid", m_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_data", m_data, 0);
    chk("midrst_rd_en", fifo_rd_en, 0);
    exp_q.delete();
    enable = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    clear_stats();
    push(8'h5A);
    push(8'h5B);
    m_ready = 1'b1;
    enable = 1'b1;
    wait_xfers(2, 20);
    repeat (4) tick();
    chk("postrst_xfers", x_cnt, 2);
    enable = 1'b0;
    wait_idle(10);

    // Randomised traffic against the in-order scoreboard.
    clear_stats();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0 && fifo_cnt < 8'd200) push(DW'($urandom_range(0, 255)));
      tick();
    end
    enable = 1'b1;
    m_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 800) begin
      tick();
      k++;
    end
    chk("random_all_delivered", exp_q.size(), 0);
    enable = 1'b0;
    wait_idle(10);

`ifdef SYN_FIFO_READER_CNT_EN
    chk("count_tracks_xfers", rd_count, xfer_since_rst % 65536);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    tick();
    enable = 1'b1;
    m_ready = 1'b1;
    k = 0;
    while (xfer_since_rst < 65537 && k < 70000) begin
      if (fifo_cnt < 8'd100) push(DW'(k));
      tick();
      k++;
    end
    m_ready = 1'b0;
    chk("count_wrap", rd_count, 1);
    m_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      tick();
      k++;
    end
    chk("count_all_delivered", exp_q.size(), 0);
    enable = 1'b0;
    wait_idle(10);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
